rad_jtag_tap: RTL



---
 rtl/rad_jtag_pkg.sv | 63 ++++++
 rtl/rad_jtag_sync.sv | 46 ++++
 rtl/rad_jtag_tap.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/rad_jtag_pkg.sv
// Shared definitions for the JTAG TAP responder.
// - tap_state_e: 1149.1 TAP states using the conventional 4-bit encoding
// - Instr*:      instruction codes that the TAP recognises
// - IrCapture:   pattern loaded into the IR shifter in Capture-IR
// - tap_next():  TAP state transition function
package rad_jtag_pkg;

    typedef enum logic [3:0] {
        TapEx2Dr   = 4'h0,
        TapEx1Dr   = 4'h1,
        TapShDr    = 4'h2,
        TapPauseDr = 4'h3,
        TapSelIr   = 4'h4,
        TapUpdDr   = 4'h5,
        TapCapDr   = 4'h6,
        TapSelDr   = 4'h7,
        TapEx2Ir   = 4'h8,
        TapEx1Ir   = 4'h9,
        TapShIr    = 4'hA,
        TapPauseIr = 4'hB,
        TapRti     = 4'hC,
        TapUpdIr   = 4'hD,
        TapCapIr   = 4'hE,
        TapTlr     = 4'hF
    } tap_state_e;

    typedef enum logic [1:0] {
        DrBypass,
        DrIdcode,
        DrUser
    } dr_sel_e;

    localparam logic [3:0] InstrIdcode = 4'h1;
    localparam logic [3:0] InstrUser   = 4'h2;
    localparam logic [3:0] InstrBypass = 4'hF;

    localparam logic [1:0] IrCapture = 2'b01;

    function automatic tap_state_e tap_next(input tap_state_e state, input logic tms);
        tap_state_e nxt;
        case (state)
            TapTlr:     nxt = tms ? TapTlr   : TapRti;
            TapRti:     nxt = tms ? TapSelDr : TapRti;
            TapSelDr:   nxt = tms ? TapSelIr : TapCapDr;
            TapCapDr:   nxt = tms ? TapEx1Dr : TapShDr;
            TapShDr:    nxt = tms ? TapEx1Dr : TapShDr;
            TapEx1Dr:   nxt = tms ? TapUpdDr : TapPauseDr;
            TapPauseDr: nxt = tms ? TapEx2Dr : TapPauseDr;
            TapEx2Dr:   nxt = tms ? TapUpdDr : TapShDr;
            TapUpdDr:   nxt = tms ? TapSelDr : TapRti;
            TapSelIr:   nxt = tms ? TapTlr   : TapCapIr;
            TapCapIr:   nxt = tms ? TapEx1Ir : TapShIr;
            TapShIr:    nxt = tms ? TapEx1Ir : TapShIr;
            TapEx1Ir:   nxt = tms ? TapUpdIr : TapPauseIr;
            TapPauseIr: nxt = tms ? TapEx2Ir : TapPauseIr;
            TapEx2Ir:   nxt = tms ? TapUpdIr : TapShIr;
            TapUpdIr:   nxt = tms ? TapSelDr : TapRti;
            default:    nxt = TapTlr;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/rad_jtag_sync.sv
// Brings the asynchronous TCK/TMS/TDI pins into the clk_i domain and detects TCK edges.
// Ports:
//   clk_i, rst_i      system clock, synchronous active-high reset
//   tck_i/tms_i/tdi_i raw JTAG pins
//   tck_rise_o        one-clk pulse on a synchronized TCK rising edge
//   tck_fall_o        one-clk pulse on a synchronized TCK falling edge
//   tms_s_o, tdi_s_o  synchronized TMS/TDI, aligned with the edge pulses
module rad_jtag_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic tck_i,
    input  logic tms_i,
    input  logic tdi_i,
    output logic tck_rise_o,
    output logic tck_fall_o,
    output logic tms_s_o,
    output logic tdi_s_o
);

    logic [SYNC_STAGES-1:0] tck_q;
    logic [SYNC_STAGES-1:0] tms_q;
    logic [SYNC_STAGES-1:0] tdi_q;
    logic                   tck_prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tck_q      <= '0;
            tms_q      <= '0;
            tdi_q      <= '0;
            tck_prev_q <= 1'b0;
        end else begin
            tck_q      <= {tck_q[SYNC_STAGES-2:0], tck_i};
            tms_q      <= {tms_q[SYNC_STAGES-2:0], tms_i};
            tdi_q      <= {tdi_q[SYNC_STAGES-2:0], tdi_i};
            tck_prev_q <= tck_q[SYNC_STAGES-1];
        end
    end

    assign tck_rise_o = tck_q[SYNC_STAGES-1] & ~tck_prev_q;
    assign tck_fall_o = ~tck_q[SYNC_STAGES-1] & tck_prev_q;
    assign tms_s_o    = tms_q[SYNC_STAGES-1];
    assign tdi_s_o    = tdi_q[SYNC_STAGES-1];

endmodule

// File: rtl/rad_jtag_tap.sv
// 1149.1-style TAP responder running entirely in the clk_i domain.
// Supports IDCODE, BYPASS and a USER data register with update strobe.
// Ports:
//   clk_i, rst_i       system clock, synchronous active-high reset
//   tck_i/tms_i/tdi_i  JTAG pins (asynchronous, oversampled)
//   tdo_o, tdo_oe_o    TDO data and its enable (high only while shifting)
//   user_capture_i     value captured into the USER DR in Capture-DR
//   user_update_o      USER DR contents latched in Update-DR
//   user_update_stb_o  one-clk pulse when user_update_o is written
//   tap_state_o        current TAP state
//   ir_o               current instruction
module rad_jtag_tap
    import rad_jtag_pkg::*;
#(
    parameter logic [31:0] IDCODE      = 32'h52444E01,
    parameter int unsigned IR_LEN      = 4,
    parameter int unsigned USER_LEN    = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                tck_i,
    input  logic                tms_i,
    input  logic                tdi_i,
    output logic                tdo_o,
    output logic                tdo_oe_o,
    input  logic [USER_LEN-1:0] user_capture_i,
    output logic [USER_LEN-1:0] user_update_o,
    output logic                user_update_stb_o,
    output logic [3:0]          tap_state_o,
    output logic [IR_LEN-1:0]   ir_o
);

    localparam logic [IR_LEN-1:0] IrIdcode = IR_LEN'(InstrIdcode);
    localparam logic [IR_LEN-1:0] IrUser   = IR_LEN'(InstrUser);
    localparam logic [IR_LEN-1:0] IrBypass = IR_LEN'(InstrBypass);

    logic tck_rise, tck_fall, tms_s, tdi_s;

    rad_jtag_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .tck_i      (tck_i),
        .tms_i      (tms_i),
        .tdi_i      (tdi_i),
        .tck_rise_o (tck_rise),
        .tck_fall_o (tck_fall),
        .tms_s_o    (tms_s),
        .tdi_s_o    (tdi_s)
    );

    tap_state_e          state_q, state_d;
    logic [IR_LEN-1:0]   ir_q, ir_d;
    logic [IR_LEN-1:0]   ir_shift_q, ir_shift_d;
    logic [31:0]         id_shift_q, id_shift_d;
    logic [USER_LEN-1:0] user_shift_q, user_shift_d;
    logic                bypass_q, bypass_d;
    logic                tdo_q, tdo_d;
    logic                tdo_oe_q, tdo_oe_d;
    logic [USER_LEN-1:0] user_update_q, user_update_d;
    logic                user_stb_q, user_stb_d;
    dr_sel_e             dr_sel;

    // Unknown instructions fall back to BYPASS.
    always_comb begin
        dr_sel = DrBypass;
        case (ir_q)
            IrIdcode: dr_sel = DrIdcode;
            IrUser:   dr_sel = DrUser;
            IrBypass: dr_sel = DrBypass;
            default:  dr_sel = DrBypass;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        ir_d          = ir_q;
        ir_shift_d    = ir_shift_q;
        id_shift_d    = id_shift_q;
        user_shift_d  = user_shift_q;
        bypass_d      = bypass_q;
        tdo_d         = tdo_q;
        tdo_oe_d      = tdo_oe_q;
        user_update_d = user_update_q;
        user_stb_d    = 1'b0;

        if (tck_rise) begin
            // Register actions use the state being left, not the one entered.
            state_d = tap_next(state_q, tms_s);
            case (state_q)
                TapTlr:   ir_d       = IrIdcode;
                TapCapIr: ir_shift_d = IR_LEN'(IrCapture);
                TapShIr:  ir_shift_d = {tdi_s, ir_shift_q[IR_LEN-1:1]};
                TapCapDr: begin
                    case (dr_sel)
                        DrIdcode: id_shift_d   = IDCODE;
                        DrUser:   user_shift_d = user_capture_i;
                        default:  bypass_d     = 1'b0;
                    endcase
                end
                TapShDr: begin
                    case (dr_sel)
                        DrIdcode: id_shift_d   = {tdi_s, id_shift_q[31:1]};
                        DrUser:   user_shift_d = {tdi_s, user_shift_q[USER_LEN-1:1]};
                        default:  bypass_d     = tdi_s;
                    endcase
                end
                default: ;
            endcase
        end else if (tck_fall) begin
            tdo_oe_d = 1'b0;
            case (state_q)
                TapShIr: begin
                    tdo_d    = ir_shift_q[0];
                    tdo_oe_d = 1'b1;
                end
                TapShDr: begin
                    case (dr_sel)
                        DrIdcode: tdo_d = id_shift_q[0];
                        DrUser:   tdo_d = user_shift_q[0];
                        default:  tdo_d = bypass_q;
                    endcase
                    tdo_oe_d = 1'b1;
                end
                TapUpdIr: ir_d = ir_shift_q;
                TapUpdDr: begin
                    if (dr_sel == DrUser) begin
                        user_update_d = user_shift_q;
                        user_stb_d    = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= TapTlr;
            ir_q          <= IrIdcode;
            ir_shift_q    <= '0;
            id_shift_q    <= '0;
            user_shift_q  <= '0;
            bypass_q      <= 1'b0;
            tdo_q         <= 1'b0;
            tdo_oe_q      <= 1'b0;
            user_update_q <= '0;
            user_stb_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            ir_q          <= ir_d;
            ir_shift_q    <= ir_shift_d;
            id_shift_q    <= id_shift_d;
            user_shift_q  <= user_shift_d;
            bypass_q      <= bypass_d;
            tdo_q         <= tdo_d;
            tdo_oe_q      <= tdo_oe_d;
            user_update_q <= user_update_d;
            user_stb_q    <= user_stb_d;
        end
    end

    assign tdo_o             = tdo_q;
    assign tdo_oe_o          = tdo_oe_q;
    assign user_update_o     = user_update_q;
    assign user_update_stb_o = user_stb_q;
    assign tap_state_o       = state_q;
    assign ir_o              = ir_q;

endmodule
